// File: rtl/score_display_decoder_if.sv
// Score-to-display bus between the score counter (master) and the display decoder (slave).
// Latency: none, wires only.
// Backpressure: none; the decoder samples the score whenever it is idle and never stalls the producer.
// Signals:
//   current_highscore  binary score from the score counter
//   bcd_out            registered BCD, digit 0 (ones) in [3:0]
//   hex_segs           active-low segments, digit k in [7k+6:7k], bit0=a .. bit6=g
//   busy               conversion in flight
//   update_done        one-cycle pulse when bcd_out/hex_segs change
interface score_display_decoder_if #(
  parameter int SCORE_WIDTH = 8,
  parameter int NUM_DIGITS  = 3
);
  logic [SCORE_WIDTH-1:0]  current_highscore;
  logic [4*NUM_DIGITS-1:0] bcd_out;
  logic [7*NUM_DIGITS-1:0] hex_segs;
  logic                    busy;
  logic                    update_done;

  modport master (
    output current_highscore,
    input  bcd_out, hex_segs, busy, update_done
  );

  modport slave (
    input  current_highscore,
    output bcd_out, hex_segs, busy, update_done
  );
endinterface

// File: rtl/score_display_decoder.sv
// Converts the binary high score to BCD (double-dabble) and drives active-low seven-segment digits.
// Latency: outputs and update_done register SCORE_WIDTH+1 edges after the edge that latches a new score.
// Backpressure: none; score changes during a conversion are ignored, latest value reconverted afterwards.
// Ports:
//   clk    system clock, all logic on posedge
//   reset  synchronous, active-high; aborts any conversion and forces a fresh one afterwards
//   bus    slave side of score_display_decoder_if (score in; bcd/segments/busy/update_done out)
module score_display_decoder #(
  parameter int SCORE_WIDTH   = 8,
  parameter int NUM_DIGITS    = 3,
  parameter bit BLANK_LEADING = 1'b1
) (
  input logic                    clk,
  input logic                    reset,
  score_display_decoder_if.slave bus
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int HW = 7 * NUM_DIGITS;
  localparam int WW = BW + SCORE_WIDTH;
  localparam int CW = $clog2(SCORE_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, state_nxt;

  // {BCD scratch, binary shift register} held as one vector so a single shift moves the MSB across.
  logic [WW-1:0]          work;
  logic [WW-1:0]          work_adj;
  logic [SCORE_WIDTH-1:0] last_latched;
  logic                   refresh;
  logic [CW-1:0]          count;

  logic                   start;
  logic                   last_iter;
  logic                   load_en;
  logic                   shift_en;
  logic                   done_en;

  logic [HW-1:0]          hex_enc;
  logic [HW-1:0]          hex_rst;
  logic [3:0]             digit;
  logic                   upper_zero;

  logic [BW-1:0]          bcd_q;
  logic [HW-1:0]          hex_q;
  logic                   busy_q;
  logic                   done_q;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // The refresh flag forces one conversion after reset even if the score equals last_latched.
  assign start     = refresh || (bus.current_highscore != last_latched);
  assign last_iter = (count == CW'(SCORE_WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output (control strobe) logic
  always_comb begin
    load_en  = 1'b0;
    shift_en = 1'b0;
    done_en  = 1'b0;
    case (state)
      IDLE:    load_en  = start;
      SHIFT:   shift_en = 1'b1;
      DONE:    done_en  = 1'b1;
      default: ;
    endcase
  end

  // Add-3 correction: any BCD digit >= 5 would exceed 9 after doubling, so pre-bias it.
  always_comb begin
    work_adj = work;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (work[SCORE_WIDTH+4*k +: 4] >= 4'd5)
        work_adj[SCORE_WIDTH+4*k +: 4] = work[SCORE_WIDTH+4*k +: 4] + 4'd3;
    end
  end

  // Segment encode of the finished scratch; walk from the top digit so upper_zero
  // says whether this digit and everything above it are zero.
  always_comb begin
    hex_enc    = '0;
    digit      = 4'd0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      digit      = work[SCORE_WIDTH+4*k +: 4];
      upper_zero = upper_zero && (digit == 4'd0);
      if (BLANK_LEADING && upper_zero && (k != 0))
        hex_enc[7*k +: 7] = 7'b1111111;
      else
        hex_enc[7*k +: 7] = seg7(digit);
    end
  end

  // Reset display: a lone '0' on digit 0, upper digits blank or '0'.
  always_comb begin
    hex_rst = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      hex_rst[7*k +: 7] = ((k == 0) || !BLANK_LEADING) ? 7'b1000000 : 7'b1111111;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      work         <= '0;
      last_latched <= '0;
      refresh      <= 1'b1;
      count        <= '0;
      bcd_q        <= '0;
      hex_q        <= hex_rst;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load_en) begin
        work         <= {{BW{1'b0}}, bus.current_highscore};
        last_latched <= bus.current_highscore;
        refresh      <= 1'b0;
        count        <= '0;
        busy_q       <= 1'b1;
      end
      if (shift_en) begin
        work  <= work_adj << 1;
        count <= count + 1'b1;
      end
      if (done_en) begin
        bcd_q  <= work[WW-1:SCORE_WIDTH];
        hex_q  <= hex_enc;
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign bus.bcd_out     = bcd_q;
  assign bus.hex_segs    = hex_q;
  assign bus.busy        = busy_q;
  assign bus.update_done = done_q;

endmodule

// File: tb/tb_score_display_decoder.sv
// Directed bench for score_display_decoder: one instance with leading-zero blanking, one without.
// Both instances see the same score and reset; expected values are hand-computed or from a decimal model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_score_display_decoder;

  logic       clk;
  logic       reset;
  logic [7:0] score;
  int         checks;
  int         errors;
  int         e;
  int         pulses;

  score_display_decoder_if #(.SCORE_WIDTH(8), .NUM_DIGITS(3)) b1 ();
  score_display_decoder_if #(.SCORE_WIDTH(8), .NUM_DIGITS(3)) b0 ();

  assign b1.current_highscore = score;
  assign b0.current_highscore = score;

  score_display_decoder #(.SCORE_WIDTH(8), .NUM_DIGITS(3), .BLANK_LEADING(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  score_display_decoder #(.SCORE_WIDTH(8), .NUM_DIGITS(3), .BLANK_LEADING(1'b0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [20:0] ref_hex(input int v, input bit blank);
    logic [6:0] s2, s1, s0;
    s2 = (blank && v < 100) ? 7'h7F : ref_seg(v / 100);
    s1 = (blank && v < 10)  ? 7'h7F : ref_seg((v / 10) % 10);
    s0 = ref_seg(v % 10);
    return {s2, s1, s0};
  endfunction

  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] d2, d1, d0;
    d2 = 4'(v / 100);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
    return {d2, d1, d0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts rising edges until update_done is seen (or the bound runs out).
  task automatic wait_pulse(input string tag, input int bound, output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!b1.update_done && edges < bound);
    chk({tag, "_pulse"}, {31'd0, b1.update_done}, 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    score  = 8'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bcd",  32'(b1.bcd_out), 32'h000);
    chk("rst_busy", {31'd0, b1.busy}, 32'd0);
    chk("rst_done", {31'd0, b1.update_done}, 32'd0);
    chk("rst_hex1", 32'(b1.hex_segs), 32'({7'h7F, 7'h7F, 7'h40}));
    chk("rst_hex0", 32'(b0.hex_segs), 32'({7'h40, 7'h40, 7'h40}));

    // Forced conversion of 0 after reset
    reset = 1'b0;
    wait_pulse("zero", 40, e);
    chk("zero_lat", 32'(e), 32'd10);
    chk("zero_bcd", 32'(b1.bcd_out), 32'h000);
    chk("zero_hex", 32'(b1.hex_segs), 32'({7'h7F, 7'h7F, 7'h40}));
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (b1.update_done) pulses++;
    end
    chk("idle_pulses", 32'(pulses), 32'd0);
    chk("idle_busy", {31'd0, b1.busy}, 32'd0);

    // 137: busy after latch, pulse 9 edges later, one cycle wide
    score = 8'd137;
    @(posedge clk);
    #1;
    chk("s137_busy", {31'd0, b1.busy}, 32'd1);
    chk("s137_hold", 32'(b1.bcd_out), 32'h000);
    wait_pulse("s137", 40, e);
    chk("s137_lat", 32'(e), 32'd9);
    chk("s137_bcd", 32'(b1.bcd_out), 32'h137);
    chk("s137_hex", 32'(b1.hex_segs), 32'({7'h79, 7'h30, 7'h78}));
    chk("s137_nbusy", {31'd0, b1.busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("s137_width", {31'd0, b1.update_done}, 32'd0);

    // 42, then 99 three cycles into SHIFT
    score = 8'd42;
    repeat (4) @(posedge clk);
    #1;
    score = 8'd99;
    wait_pulse("s42", 40, e);
    chk("s42_lat", 32'(e), 32'd6);
    chk("s42_bcd", 32'(b1.bcd_out), 32'h042);
    chk("s42_hex1", 32'(b1.hex_segs), 32'({7'h7F, 7'h19, 7'h24}));
    chk("s42_hex0", 32'(b0.hex_segs), 32'({7'h40, 7'h19, 7'h24}));
    wait_pulse("s99", 40, e);
    chk("s99_lat", 32'(e), 32'd10);
    chk("s99_bcd", 32'(b1.bcd_out), 32'h099);
    chk("s99_hex", 32'(b1.hex_segs), 32'({7'h7F, 7'h10, 7'h10}));

    // 255 -> 0 wrap, then 100
    score = 8'd255;
    wait_pulse("s255", 40, e);
    chk("s255_bcd", 32'(b1.bcd_out), 32'h255);
    chk("s255_hex", 32'(b1.hex_segs), 32'({7'h24, 7'h12, 7'h12}));
    score = 8'd0;
    wait_pulse("wrap", 40, e);
    chk("wrap_bcd", 32'(b1.bcd_out), 32'h000);
    chk("wrap_hex", 32'(b1.hex_segs), 32'({7'h7F, 7'h7F, 7'h40}));
    score = 8'd100;
    wait_pulse("s100", 40, e);
    chk("s100_bcd", 32'(b1.bcd_out), 32'h100);
    chk("s100_hex", 32'(b1.hex_segs), 32'({7'h79, 7'h40, 7'h40}));

    // Reset during SHIFT with 200
    score = 8'd200;
    repeat (4) @(posedge clk);
    #1;
    reset  = 1'b1;
    pulses = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (b1.update_done) pulses++;
    end
    chk("mrst_pulses", 32'(pulses), 32'd0);
    chk("mrst_bcd", 32'(b1.bcd_out), 32'h000);
    chk("mrst_busy", {31'd0, b1.busy}, 32'd0);
    chk("mrst_hex", 32'(b1.hex_segs), 32'({7'h7F, 7'h7F, 7'h40}));
    reset = 1'b0;
    wait_pulse("s200", 40, e);
    chk("s200_lat", 32'(e), 32'd10);
    chk("s200_bcd", 32'(b1.bcd_out), 32'h200);
    chk("s200_hex", 32'(b1.hex_segs), 32'({7'h24, 7'h40, 7'h40}));

    // No blanking instance with 5
    score = 8'd5;
    wait_pulse("s5", 40, e);
    chk("s5_hex0", 32'(b0.hex_segs), 32'({7'h40, 7'h40, 7'h12}));
    chk("s5_hex1", 32'(b1.hex_segs), 32'({7'h7F, 7'h7F, 7'h12}));

    // Sweep against the decimal model
    for (int v = 0; v < 256; v++) begin
      score = 8'(v);
      wait_pulse("sweep", 40, e);
      chk("sweep_lat",  32'(e), 32'd10);
      chk("sweep_bcd",  32'(b1.bcd_out), 32'(ref_bcd(v)));
      chk("sweep_hex1", 32'(b1.hex_segs), 32'(ref_hex(v, 1'b1)));
      chk("sweep_hex0", 32'(b0.hex_segs), 32'(ref_hex(v, 1'b0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
